ila_fifo_cascade_n: RTL and testbench

- Single-clock capture FIFO for the ILA sample path.
- Built from STAGES equal memory segments that are chained into one logical FIFO of depth STAGES*SEG_DEPTH.
- Segments are used as a ring: writes fill segment 0, then 1, and so on, wrapping back to 0. Reads drain in strict write order across segment boundaries, with no dead zones and no idle gap between segments.
- Adds features the earlier cascade lacked:
  - arbitrary stage count
  - exact occupancy output
  - sticky overflow/underflow flags
  - synchronous flush
  - read-data valid strobe

---
 rtl/ila_fifo_cascade_n_if.sv | 39 +++
 rtl/ila_fifo_cascade_n.sv | 191 +++++++++++++++++++
 tb/tb_ila_fifo_cascade_n.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ila_fifo_cascade_n_if.sv
// Sample-path bundle for the segmented ILA capture FIFO.
// The design takes the slave side; the producer/consumer takes the master side.
interface ila_fifo_cascade_n_if #(
    parameter int WIDTH     = 20,
    parameter int STAGES    = 3,
    parameter int SEG_DEPTH = 512
);
    localparam int D     = STAGES * SEG_DEPTH;
    localparam int LVL_W = $clog2(D + 1);
    localparam int SEG_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic             clear_i;
    logic             push_i;
    logic [WIDTH-1:0] di;
    logic             pop_i;
    logic [WIDTH-1:0] do_o;
    logic             do_valid_o;
    logic             full_o;
    logic             almost_full_o;
    logic             empty_o;
    logic             almost_empty_o;
    logic [LVL_W-1:0] level_o;
    logic [SEG_W-1:0] wr_seg_o;
    logic [SEG_W-1:0] rd_seg_o;
    logic             overflow_o;
    logic             underflow_o;

    modport slave (
        input  clear_i, push_i, di, pop_i,
        output do_o, do_valid_o, full_o, almost_full_o, empty_o, almost_empty_o,
               level_o, wr_seg_o, rd_seg_o, overflow_o, underflow_o
    );

    modport master (
        output clear_i, push_i, di, pop_i,
        input  do_o, do_valid_o, full_o, almost_full_o, empty_o, almost_empty_o,
               level_o, wr_seg_o, rd_seg_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/ila_fifo_cascade_n.sv
// Single-clock capture FIFO built from STAGES equal segments used as a ring,
// with registered read data, exact occupancy, sticky error flags and flush.
module ila_fifo_cascade_n #(
    parameter int WIDTH               = 20,
    parameter int STAGES              = 3,
    parameter int SEG_DEPTH           = 512,
    parameter int ALMOST_FULL_OFFSET  = 3,
    parameter int ALMOST_EMPTY_OFFSET = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    ila_fifo_cascade_n_if.slave   bus
);
    localparam int D      = STAGES * SEG_DEPTH;
    localparam int LVL_W  = $clog2(D + 1);
    localparam int SEG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int AW     = $clog2(SEG_DEPTH);
    localparam int AF_INT = (ALMOST_FULL_OFFSET >= D) ? 0 : D - ALMOST_FULL_OFFSET;
    localparam int AE_INT = (ALMOST_EMPTY_OFFSET >= D) ? D : ALMOST_EMPTY_OFFSET;

    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(D);
    localparam logic [LVL_W-1:0] AF_THR    = LVL_W'(AF_INT);
    localparam logic [LVL_W-1:0] AE_THR    = LVL_W'(AE_INT);
    localparam logic [SEG_W-1:0] SEG_LAST  = SEG_W'(STAGES - 1);
    localparam logic [AW-1:0]    ADDR_LAST = AW'(SEG_DEPTH - 1);

    // Segment index advance; wraps from the last segment back to segment 0.
    function automatic logic [SEG_W-1:0] seg_inc(input logic [SEG_W-1:0] seg);
        logic [SEG_W-1:0] nxt;
        if (seg == SEG_LAST) begin
            nxt = {SEG_W{1'b0}};
        end else begin
            nxt = seg + SEG_W'(1);
        end
        return nxt;
    endfunction

    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [SEG_W-1:0] wr_seg_q,  wr_seg_d;
    logic [SEG_W-1:0] rd_seg_q,  rd_seg_d;
    logic [LVL_W-1:0] level_q,   level_d;
    logic             full_q,    full_d;
    logic             afull_q,   afull_d;
    logic             empty_q,   empty_d;
    logic             aempty_q,  aempty_d;
    logic             ovf_q,     ovf_d;
    logic             unf_q,     unf_d;
    logic [WIDTH-1:0] do_q,      do_d;
    logic             do_vld_q,  do_vld_d;

    logic             push_acc_s;
    logic             pop_acc_s;
    logic [STAGES-1:0] seg_we_s;
    logic [WIDTH-1:0] seg_rd_s [STAGES];
    logic [WIDTH-1:0] rd_word_s;

    // Flush wins over both requests; flags are the pre-edge registered ones.
    assign push_acc_s = bus.push_i & ~full_q  & ~bus.clear_i;
    assign pop_acc_s  = bus.pop_i  & ~empty_q & ~bus.clear_i;

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        logic [WIDTH-1:0] mem_q [SEG_DEPTH];

        assign seg_we_s[g] = push_acc_s & (wr_seg_q == SEG_W'(g));
        assign seg_rd_s[g] = mem_q[rd_addr_q];

        // Segment storage write port, enabled only while this segment is the write target.
        always_ff @(posedge clk) begin
            if (seg_we_s[g]) begin
                mem_q[wr_addr_q] <= bus.di;
            end
        end
    end

    // Read mux across segments, selected by the read segment index.
    always_comb begin
        rd_word_s = {WIDTH{1'b0}};
        for (int s = 0; s < STAGES; s++) begin
            rd_word_s = (rd_seg_q == SEG_W'(s)) ? seg_rd_s[s] : rd_word_s;
        end
    end

    // Next-state for pointers, level, flags and read data.
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        wr_seg_d  = wr_seg_q;
        rd_seg_d  = rd_seg_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        do_d      = do_q;
        do_vld_d  = 1'b0;

        if (bus.clear_i) begin
            wr_addr_d = {AW{1'b0}};
            rd_addr_d = {AW{1'b0}};
            wr_seg_d  = {SEG_W{1'b0}};
            rd_seg_d  = {SEG_W{1'b0}};
            level_d   = {LVL_W{1'b0}};
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
        end else begin
            if (push_acc_s) begin
                wr_addr_d = wr_addr_q + AW'(1);
                wr_seg_d  = (wr_addr_q == ADDR_LAST) ? seg_inc(wr_seg_q) : wr_seg_q;
            end else begin
                wr_addr_d = wr_addr_q;
            end

            if (pop_acc_s) begin
                rd_addr_d = rd_addr_q + AW'(1);
                rd_seg_d  = (rd_addr_q == ADDR_LAST) ? seg_inc(rd_seg_q) : rd_seg_q;
                do_d      = rd_word_s;
                do_vld_d  = 1'b1;
            end else begin
                rd_addr_d = rd_addr_q;
            end

            case ({push_acc_s, pop_acc_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            // A push dropped while a pop drains the full FIFO is not an overflow; likewise underflow.
            if (bus.push_i & full_q & ~bus.pop_i) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end

            if (bus.pop_i & empty_q & ~bus.push_i) begin
                unf_d = 1'b1;
            end else begin
                unf_d = unf_q;
            end
        end

        full_d   = (level_d == LVL_MAX);
        empty_d  = (level_d == {LVL_W{1'b0}});
        afull_d  = (level_d >= AF_THR);
        aempty_d = (level_d <= AE_THR);
    end

    // State registers; reset is asynchronous and also clears the read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= {AW{1'b0}};
            rd_addr_q <= {AW{1'b0}};
            wr_seg_q  <= {SEG_W{1'b0}};
            rd_seg_q  <= {SEG_W{1'b0}};
            level_q   <= {LVL_W{1'b0}};
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            do_q      <= {WIDTH{1'b0}};
            do_vld_q  <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            wr_seg_q  <= wr_seg_d;
            rd_seg_q  <= rd_seg_d;
            level_q   <= level_d;
            full_q    <= full_d;
            afull_q   <= afull_d;
            empty_q   <= empty_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            do_q      <= do_d;
            do_vld_q  <= do_vld_d;
        end
    end

    assign bus.do_o           = do_q;
    assign bus.do_valid_o     = do_vld_q;
    assign bus.full_o         = full_q;
    assign bus.almost_full_o  = afull_q;
    assign bus.empty_o        = empty_q;
    assign bus.almost_empty_o = aempty_q;
    assign bus.level_o        = level_q;
    assign bus.wr_seg_o       = wr_seg_q;
    assign bus.rd_seg_o       = rd_seg_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.underflow_o    = unf_q;
endmodule

// File: tb/tb_ila_fifo_cascade_n.sv
// Directed bench for ila_fifo_cascade_n: 3 segments of 4 words, 8-bit samples.
module tb_ila_fifo_cascade_n;
    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    ila_fifo_cascade_n_if #(.WIDTH(8), .STAGES(3), .SEG_DEPTH(4)) bus ();

    ila_fifo_cascade_n #(
        .WIDTH(8), .STAGES(3), .SEG_DEPTH(4),
        .ALMOST_FULL_OFFSET(3), .ALMOST_EMPTY_OFFSET(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Occupancy and the four level-derived flags for D=12, AF at 9, AE at 2.
    task automatic chk_lvl(input string tag, input int lvl);
        chk({tag, ".level"},  32'(bus.level_o),        32'(lvl));
        chk({tag, ".empty"},  32'(bus.empty_o),        32'(lvl == 0));
        chk({tag, ".full"},   32'(bus.full_o),         32'(lvl == 12));
        chk({tag, ".afull"},  32'(bus.almost_full_o),  32'(lvl >= 9));
        chk({tag, ".aempty"}, 32'(bus.almost_empty_o), 32'(lvl <= 2));
    endtask

    task automatic cyc(input logic p, input logic q, input logic c, input logic [7:0] d);
        bus.push_i  = p;
        bus.pop_i   = q;
        bus.clear_i = c;
        bus.di      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp, input int lvl);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk({tag, ".do"},    32'(bus.do_o),       32'(exp));
        chk({tag, ".valid"}, 32'(bus.do_valid_o), 32'd1);
        chk_lvl(tag, lvl);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.clear_i = 1'b0; bus.di = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_lvl("rst", 0);
        chk("rst.do",    32'(bus.do_o),        32'd0);
        chk("rst.valid", 32'(bus.do_valid_o),  32'd0);
        chk("rst.ovf",   32'(bus.overflow_o),  32'd0);
        chk("rst.unf",   32'(bus.underflow_o), 32'd0);
        chk("rst.wseg",  32'(bus.wr_seg_o),    32'd0);
        chk("rst.rseg",  32'(bus.rd_seg_o),    32'd0);
        rst = 1'b0;

        // Fill and drain, watching the write/read segment steps.
        for (int i = 1; i <= 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(i));
            chk_lvl("fill", i);
            chk("fill.wseg", 32'(bus.wr_seg_o), 32'((i / 4) % 3));
        end
        for (int i = 1; i <= 12; i++) begin
            pop_chk("drain", 8'(i), 12 - i);
            chk("drain.rseg", 32'(bus.rd_seg_o), 32'((i / 4) % 3));
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("drain.idle.valid", 32'(bus.do_valid_o), 32'd0);
        chk("drain.idle.do",    32'(bus.do_o),       32'h0C);

        // Ring wrap: offset by 6, then a full pass that wraps through segment 0.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 6; i++) pop_chk("pre", 8'(8'h10 + i), 5 - i);
        chk("wrap.wseg0", 32'(bus.wr_seg_o), 32'd1);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
            chk_lvl("wrap.fill", i + 1);
        end
        for (int i = 0; i < 12; i++) pop_chk("wrap.drain", 8'(8'h20 + i), 11 - i);

        // Boundary handshakes at full and at empty.
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        chk_lvl("bnd.full", 12);
        cyc(1'b1, 1'b1, 1'b0, 8'h99);
        chk_lvl("bnd.pp_full", 11);
        chk("bnd.pp_full.do",  32'(bus.do_o),       32'h40);
        chk("bnd.pp_full.ovf", 32'(bus.overflow_o), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h4C);
        cyc(1'b1, 1'b0, 1'b0, 8'h77);
        chk_lvl("bnd.ovf", 12);
        chk("bnd.ovf.flag", 32'(bus.overflow_o), 32'd1);
        for (int i = 0; i < 12; i++) pop_chk("bnd.drain", 8'(8'h41 + i), 11 - i);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("bnd.unf.flag",  32'(bus.underflow_o), 32'd1);
        chk("bnd.unf.valid", 32'(bus.do_valid_o),  32'd0);
        chk_lvl("bnd.unf", 0);
        cyc(1'b1, 1'b1, 1'b0, 8'h66);
        chk_lvl("bnd.pp_empty", 1);
        chk("bnd.pp_empty.valid", 32'(bus.do_valid_o), 32'd0);
        chk("bnd.pp_empty.do",    32'(bus.do_o),       32'h4C);
        pop_chk("bnd.pp_empty.pop", 8'h66, 0);

        // Almost-empty threshold on the way down from 4.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h70 + i));
        chk_lvl("ae.start", 4);
        for (int i = 0; i < 4; i++) pop_chk("ae.pop", 8'(8'h70 + i), 3 - i);

        // Flush with a competing push while overflow is sticky.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
        chk_lvl("fl.pre", 7);
        chk("fl.pre.ovf", 32'(bus.overflow_o), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 8'h88);
        chk_lvl("fl.post", 0);
        chk("fl.ovf",   32'(bus.overflow_o),  32'd0);
        chk("fl.unf",   32'(bus.underflow_o), 32'd0);
        chk("fl.valid", 32'(bus.do_valid_o),  32'd0);
        chk("fl.wseg",  32'(bus.wr_seg_o),    32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h55);
        pop_chk("fl.after", 8'h55, 0);

        // Asynchronous reset in the middle of a push burst.
        cyc(1'b1, 1'b0, 1'b0, 8'h31);
        cyc(1'b1, 1'b0, 1'b0, 8'h32);
        bus.di = 8'h33;
        #3;
        rst = 1'b1;
        #1;
        chk_lvl("arst", 0);
        chk("arst.do",    32'(bus.do_o),       32'd0);
        chk("arst.valid", 32'(bus.do_valid_o), 32'd0);
        bus.push_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 8'hA5);
        chk_lvl("arst.push", 1);
        pop_chk("arst.pop", 8'hA5, 0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
